// File: rtl/sonic_circbuf_ptr.sv
// sonic_circbuf_ptr: circular-buffer pointer engine for the SONIC TX/RX rings.
// The producer advances wr_ptr one entry per accepted incr; the host returns
// entries in bulk via rel_valid/rel_count. Tracks occupancy and status flags,
// wraps at an arbitrary DEPTH and presents a registered BASE-offset address.
// Optional build macro SONIC_CIRCBUF_STATS_EN adds saturating wrap_cnt and
// drop_cnt counters.
module sonic_circbuf_ptr #(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 15872,
  parameter int BASE      = 0,
  parameter int AF_THRESH = 15360
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              ena,
  input  logic              incr,
  input  logic              rel_valid,
  input  logic [ADDR_W:0]   rel_count,
  output logic [ADDR_W-1:0] addr_out,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              wrap,
  output logic              overflow,
  output logic              underflow
`ifdef SONIC_CIRCBUF_STATS_EN
  ,
  output logic [31:0]       wrap_cnt,
  output logic [31:0]       drop_cnt
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   AF_L    = (ADDR_W+1)'(AF_THRESH);

  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d, addr_q, addr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d, full_q, full_d, af_q, af_d;
  logic              wrap_q, wrap_d, ovf_q, ovf_d, unf_q, unf_d;

  logic              inc_acc_s, drop_s, rel_over_s;
  logic [ADDR_W:0]   rel_eff_s, rd_sum_s, rd_red_s;

`ifdef SONIC_CIRCBUF_STATS_EN
  logic [31:0]       wrap_cnt_q, wrap_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

  // Accept/drop/release decisions, all judged on the pre-cycle level.
  always_comb begin
    inc_acc_s  = incr & ena & (level_q < DEPTH_L);
    drop_s     = incr & ena & (level_q >= DEPTH_L);
    rel_over_s = rel_valid & (rel_count > level_q);
    if (!rel_valid) begin
      rel_eff_s = '0;
    end else if (rel_over_s) begin
      rel_eff_s = level_q;
    end else begin
      rel_eff_s = rel_count;
    end
    // rd_ptr < DEPTH and rel_eff <= DEPTH, so one subtract brings it back in range.
    rd_sum_s = {1'b0, rd_q} + rel_eff_s;
    if (rd_sum_s >= DEPTH_L) begin
      rd_red_s = rd_sum_s - DEPTH_L;
    end else begin
      rd_red_s = rd_sum_s;
    end
  end

  // Next-state for pointers, level and flags; clear overrides all traffic.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // The address always follows the pointer register, even across clear.
    addr_d  = BASE_L + wr_q;
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (inc_acc_s) begin
        if (wr_q == LAST_L) begin
          wr_d   = '0;
          wrap_d = 1'b1;
        end else begin
          wr_d   = wr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end else begin
        wr_d = wr_q;
      end
      rd_d    = rd_red_s[ADDR_W-1:0];
      level_d = level_q + {{ADDR_W{1'b0}}, inc_acc_s} - rel_eff_s;
      ovf_d   = ovf_q | drop_s;
      unf_d   = unf_q | rel_over_s;
    end
    // Flags derive from the next level so they line up with level.
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
    af_d    = (level_d >= AF_L);
  end

`ifdef SONIC_CIRCBUF_STATS_EN
  // Saturating event counters, flushed by clear.
  always_comb begin
    if (clear) begin
      wrap_cnt_d = 32'd0;
      drop_cnt_d = 32'd0;
    end else begin
      if (wrap_d && (wrap_cnt_q != 32'hFFFF_FFFF)) begin
        wrap_cnt_d = wrap_cnt_q + 32'd1;
      end else begin
        wrap_cnt_d = wrap_cnt_q;
      end
      if (drop_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wrap_cnt_q <= 32'd0;
      drop_cnt_q <= 32'd0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  // State and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign addr_out    = addr_q;
  assign wr_ptr      = wr_q;
  assign rd_ptr      = rd_q;
  assign level       = level_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wrap        = wrap_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_sonic_circbuf_ptr.sv
// Bench for sonic_circbuf_ptr: a small DEPTH=8 instance checked against a
// behavioural ring model, plus a default-size instance for the wrap boundary.
module tb_sonic_circbuf_ptr;

  localparam int SW = 4, SD = 8, SB = 2, SAF = 6;
  localparam int BW = 14, BD = 15872, BB = 'h100, BAF = 15360;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // small instance
  logic          s_clear = 1'b0, s_ena = 1'b0, s_incr = 1'b0, s_rv = 1'b0;
  logic [SW:0]   s_rc = '0;
  logic [SW-1:0] s_addr, s_wr, s_rd;
  logic [SW:0]   s_level;
  logic          s_empty, s_full, s_af, s_wrap, s_ovf, s_unf;

  // default-size instance
  logic          b_clear = 1'b0, b_ena = 1'b0, b_incr = 1'b0, b_rv = 1'b0;
  logic [BW:0]   b_rc = '0;
  logic [BW-1:0] b_addr, b_wr, b_rd;
  logic [BW:0]   b_level;
  logic          b_empty, b_full, b_af, b_wrap, b_ovf, b_unf;

`ifdef SONIC_CIRCBUF_STATS_EN
  logic [31:0] s_wcnt, s_dcnt, b_wcnt, b_dcnt;
`endif

  sonic_circbuf_ptr #(.ADDR_W(SW), .DEPTH(SD), .BASE(SB), .AF_THRESH(SAF)) u_small (
    .clk_in(clk), .reset_n(rst_n), .clear(s_clear), .ena(s_ena), .incr(s_incr),
    .rel_valid(s_rv), .rel_count(s_rc), .addr_out(s_addr), .wr_ptr(s_wr),
    .rd_ptr(s_rd), .level(s_level), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .wrap(s_wrap), .overflow(s_ovf), .underflow(s_unf)
`ifdef SONIC_CIRCBUF_STATS_EN
    , .wrap_cnt(s_wcnt), .drop_cnt(s_dcnt)
`endif
  );

  sonic_circbuf_ptr #(.ADDR_W(BW), .DEPTH(BD), .BASE(BB), .AF_THRESH(BAF)) u_big (
    .clk_in(clk), .reset_n(rst_n), .clear(b_clear), .ena(b_ena), .incr(b_incr),
    .rel_valid(b_rv), .rel_count(b_rc), .addr_out(b_addr), .wr_ptr(b_wr),
    .rd_ptr(b_rd), .level(b_level), .empty(b_empty), .full(b_full),
    .almost_full(b_af), .wrap(b_wrap), .overflow(b_ovf), .underflow(b_unf)
`ifdef SONIC_CIRCBUF_STATS_EN
    , .wrap_cnt(b_wcnt), .drop_cnt(b_dcnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model of the small ring
  int m_level, m_wr, m_rd, m_addr;
  bit m_ovf, m_unf, m_wrap;

  task automatic model_reset();
    m_level = 0; m_wr = 0; m_rd = 0; m_addr = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_wrap = 1'b0;
  endtask

  // Drive one cycle on the small instance (called at a negedge), advance the
  // model by the ring rules, and return at the next negedge.
  task automatic cyc(input bit clr, input bit en, input bit inc, input bit rv, input int rc);
    bit acc;
    int eff;
    s_clear = clr; s_ena = en; s_incr = inc; s_rv = rv; s_rc = (SW+1)'(rc);
    @(posedge clk);
    if (clr) begin
      m_addr = SB + m_wr;
      m_wr = 0; m_rd = 0; m_level = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_wrap = 1'b0;
    end else begin
      acc = inc && en && (m_level < SD);
      if (inc && en && (m_level == SD)) m_ovf = 1'b1;
      eff = 0;
      if (rv) begin
        eff = (rc < m_level) ? rc : m_level;
        if (rc > m_level) m_unf = 1'b1;
      end
      m_addr  = SB + m_wr;
      m_wrap  = acc && (m_wr == SD - 1);
      if (acc) m_wr = (m_wr + 1) % SD;
      m_rd    = (m_rd + eff) % SD;
      m_level = m_level + (acc ? 1 : 0) - eff;
    end
    @(negedge clk);
    s_clear = 1'b0; s_ena = 1'b0; s_incr = 1'b0; s_rv = 1'b0; s_rc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_tests++;
    if ({s_wr, s_rd, s_level, s_addr} !== 17'd0) begin
      n_fail++; $display("FAIL reset_ptrs: got %h expected 0", {s_wr, s_rd, s_level, s_addr});
    end
    n_tests++;
    if ({s_empty, s_full, s_af, s_wrap, s_ovf, s_unf} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 100000", {s_empty, s_full, s_af, s_wrap, s_ovf, s_unf});
    end
    n_tests++;
    if ({b_addr, b_empty} !== {14'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_big: addr=%h empty=%b expected 0/1", b_addr, b_empty);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < SD; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
      n_tests++;
      if (s_wrap !== (i == SD - 1)) begin
        n_fail++; $display("FAIL fill_wrap[%0d]: got %b expected %b", i, s_wrap, (i == SD - 1));
      end
    end
    n_tests++;
    if ({s_level, s_full, s_af, s_wr, s_ovf} !== {5'd8, 1'b1, 1'b1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL fill_full: level=%0d full=%b af=%b wr=%0d ovf=%b expected 8/1/1/0/0",
                         s_level, s_full, s_af, s_wr, s_ovf);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);   // incr without ena: silently ignored
    n_tests++;
    if ({s_level, s_ovf} !== {5'd8, 1'b0}) begin
      n_fail++; $display("FAIL fill_noena: level=%0d ovf=%b expected 8/0", s_level, s_ovf);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);   // 9th incr: dropped
    n_tests++;
    if ({s_level, s_ovf, s_wrap, s_wr} !== {5'd8, 1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL fill_ovf: level=%0d ovf=%b wrap=%b wr=%0d expected 8/1/0/0",
                         s_level, s_ovf, s_wrap, s_wr);
    end
  endtask

  task automatic test_release();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 6);
    repeat (5) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    n_tests++;
    if ({s_level, s_rd} !== {5'd5, 4'd6}) begin
      n_fail++; $display("FAIL rel_setup: level=%0d rd=%0d expected 5/6", s_level, s_rd);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4);
    n_tests++;
    if ({s_rd, s_level, s_unf} !== {4'd2, 5'd1, 1'b0}) begin
      n_fail++; $display("FAIL rel_wrap: rd=%0d level=%0d unf=%b expected 2/1/0", s_rd, s_level, s_unf);
    end
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 5);
    n_tests++;
    if ({s_rd, s_level, s_empty, s_unf} !== {4'd5, 5'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rel_under: rd=%0d level=%0d empty=%b unf=%b expected 5/0/1/1",
                         s_rd, s_level, s_empty, s_unf);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);   // zero-count release is a no-op
    n_tests++;
    if ({s_rd, s_level} !== {4'd5, 5'd0}) begin
      n_fail++; $display("FAIL rel_zero: rd=%0d level=%0d expected 5/0", s_rd, s_level);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    repeat (SD) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 2);   // full: write dropped despite release
    n_tests++;
    if ({s_level, s_ovf, s_wr, s_rd} !== {5'd6, 1'b1, 4'd0, 4'd2}) begin
      n_fail++; $display("FAIL b2b_full: level=%0d ovf=%b wr=%0d rd=%0d expected 6/1/0/2",
                         s_level, s_ovf, s_wr, s_rd);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
    n_tests++;
    if ({s_level, s_wr, s_rd} !== {5'd4, 4'd1, 4'd5}) begin
      n_fail++; $display("FAIL b2b_both: level=%0d wr=%0d rd=%0d expected 4/1/5", s_level, s_wr, s_rd);
    end
  endtask

  task automatic test_clear();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 7);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1);
    n_tests++;
    if ({s_wr, s_rd, s_level, s_empty, s_ovf, s_unf, s_wrap} !== {4'd0, 4'd0, 5'd0, 4'b1000}) begin
      n_fail++; $display("FAIL clear_state: wr=%0d rd=%0d level=%0d e/o/u/w=%b expected 0/0/0/1000",
                         s_wr, s_rd, s_level, {s_empty, s_ovf, s_unf, s_wrap});
    end
    n_tests++;
    if (s_addr !== 4'd7) begin
      n_fail++; $display("FAIL clear_addr_lag: got %0d expected 7", s_addr);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
    n_tests++;
    if (s_addr !== 4'(SB)) begin
      n_fail++; $display("FAIL clear_addr_base: got %0d expected %0d", s_addr, SB);
    end
  endtask

  task automatic test_random();
    logic [22:0] exp_v, act_v;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, SD + 2));
      exp_v = {m_wr[3:0], m_rd[3:0], m_level[4:0], m_addr[3:0],
               (m_level == 0), (m_level == SD), (m_level >= SAF), m_wrap, m_ovf, m_unf};
      act_v = {s_wr, s_rd, s_level, s_addr, s_empty, s_full, s_af, s_wrap, s_ovf, s_unf};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL rand[%0d]: got %h expected %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (4) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({s_wr, s_rd, s_level, s_addr, s_empty, s_full, s_af, s_wrap, s_ovf, s_unf} !== {17'd0, 6'b100000}) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h",
                         {s_wr, s_rd, s_level, s_addr, s_empty, s_full, s_af, s_wrap, s_ovf, s_unf},
                         {17'd0, 6'b100000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_wrap();
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0; b_ena = 1'b1; b_incr = 1'b1;
    repeat (BD - 1) @(negedge clk);
    b_incr = 1'b0;
    n_tests++;
    if ({b_wr, b_level, b_af, b_full, b_wrap} !== {14'h3DFF, 15'h3DFF, 3'b100}) begin
      n_fail++; $display("FAIL big_last: wr=%h level=%h af/full/wrap=%b expected 3dff/3dff/100",
                         b_wr, b_level, {b_af, b_full, b_wrap});
    end
    n_tests++;
    if (b_addr !== 14'h3EFE) begin
      n_fail++; $display("FAIL big_addr_lag: got %h expected 3efe", b_addr);
    end
    @(negedge clk);
    n_tests++;
    if (b_addr !== 14'h3EFF) begin
      n_fail++; $display("FAIL big_addr: got %h expected 3eff", b_addr);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({b_wr, b_wrap} !== {14'h3DFF, 1'b0}) begin
        n_fail++; $display("FAIL big_idle[%0d]: wr=%h wrap=%b expected 3dff/0", i, b_wr, b_wrap);
      end
    end
    b_incr = 1'b1;
    @(negedge clk);
    b_incr = 1'b0;
    n_tests++;
    if ({b_wr, b_wrap, b_full, b_level} !== {14'h0, 1'b1, 1'b1, 15'd15872}) begin
      n_fail++; $display("FAIL big_wrap: wr=%h wrap=%b full=%b level=%0d expected 0/1/1/15872",
                         b_wr, b_wrap, b_full, b_level);
    end
    @(negedge clk);
    n_tests++;
    if ({b_addr, b_wrap} !== {14'h100, 1'b0}) begin
      n_fail++; $display("FAIL big_base: addr=%h wrap=%b expected 100/0", b_addr, b_wrap);
    end
    b_ena = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_back_to_back();
    test_clear();
    test_random();
    test_async_reset();
    test_random();
    test_default_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sonic_circbuf_ptr.md
Name: sonic_circbuf_ptr

Overview:
- Parametrised circular-buffer pointer engine for the SONIC TX/RX ring buffers.
- The producer advances a write pointer one entry per accepted `incr`. The host returns entries in bulk through `rel_valid`/`rel_count`.
- The block tracks occupancy and full/empty/almost-full, wraps at an arbitrary non-power-of-2 depth, and presents a registered, base-offset buffer address to the DMA/memory side.

Parameters:
- ADDR_W, 14, pointer/address width in bits.
- DEPTH, 15872 (0x3E00), ring entries; 2 <= DEPTH <= 2**ADDR_W.
- BASE, 0, offset added to the pointer to form `addr_out`; BASE+DEPTH-1 < 2**ADDR_W.
- AF_THRESH, 15360, level at or above which `almost_full` asserts.

Ports:
- clk_in  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of pointers, level and sticky flags.
- ena  in  1  channel enable; gates `incr` only.
- incr  in  1  producer advance request, one entry.
- rel_valid  in  1  host release strobe.
- rel_count  in  ADDR_W+1  entries released with `rel_valid`.
- addr_out  out  ADDR_W  BASE + wr_ptr, registered.
- wr_ptr  out  ADDR_W  current write pointer, 0..DEPTH-1.
- rd_ptr  out  ADDR_W  current read pointer, 0..DEPTH-1.
- level  out  ADDR_W+1  occupied entries, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- almost_full  out  1  level>=AF_THRESH.
- wrap  out  1  one-cycle pulse when wr_ptr wraps DEPTH-1 -> 0.
- overflow  out  1  sticky: `incr` dropped while full.
- underflow  out  1  sticky: `rel_count` exceeded level.

Behaviour:
- Reset (reset_n low, async): all pointers, level, `addr_out`, `wrap`, `overflow`, `underflow`, `full` and `almost_full` = 0; `empty` = 1.
- All outputs are registered. Flags are computed from the next-state level, so they are coherent with `level` in the same cycle.
- Accept: `inc_acc = incr & ena & (level < DEPTH)`. Fullness is judged on the pre-cycle level; a same-cycle release does not admit a write while full.
- Accepted `incr` advances wr_ptr by 1. At DEPTH-1 it goes to 0 and `wrap` pulses for that cycle.
- The pointer never wraps without an accepted advance. It holds at DEPTH-1 until the next accept.
- Dropped write: `incr & ena & full` drops the write and sets `overflow`. `incr` with `ena` low is ignored silently.
- Release: `rel_valid` gives `rel_eff = min(rel_count, level)` using the pre-cycle level. If `rel_count > level`, set `underflow`.
- rd_ptr update: `rd_ptr <= rd_ptr + rel_eff`, reduced mod DEPTH by a single conditional subtract; ADDR_W+1-bit intermediate, no overflow.
- `rel_count == 0` with `rel_valid` is a legal no-op.
- Same-cycle accept and release: `level <= level + inc_acc - rel_eff`. Both pointers update in that cycle.
- `addr_out` = BASE + wr_ptr, registered one cycle after wr_ptr: 1-cycle latency from the pointer, 2 cycles from `incr`.
- `clear` has priority over `incr`/`rel_valid`. Next cycle: pointers 0, level 0, `empty`=1, sticky flags 0, `addr_out` returns to BASE one cycle after the pointer.
- Reset asserted mid-operation takes effect immediately. Deassertion is assumed synchronised externally.

Optional Feature:
- Macro: SONIC_CIRCBUF_STATS_EN.
- With the macro defined, two extra outputs are added:
  - `wrap_cnt` [31:0]: counts `wrap` pulses.
  - `drop_cnt` [31:0]: counts dropped writes.
- Both counters saturate at 0xFFFFFFFF and are cleared by reset_n or `clear`.
- Without the macro, the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- DEPTH=8: reset, then 8 `incr` with `ena`=1 -> level=8, `full`=1, wr_ptr=0, one `wrap` pulse on the 8th accept; a 9th `incr` -> `overflow`=1, level stays 8.
- DEPTH=8, level=5, rd_ptr=6: `rel_count`=4 -> rd_ptr=2, level=1, `underflow`=0.
- level=3: `rel_count`=5 -> rd_ptr advances 3, level=0, `empty`=1, `underflow`=1.
- Full (level=8) with simultaneous `incr` and `rel_count`=2 -> `incr` dropped, `overflow`=1, level=6; non-full level=4 with `incr`+`rel_count`=1 -> level=4, both pointers move.
- Default params, BASE=0x100: 0x3DFF accepts -> wr_ptr=0x3DFF, `addr_out`=0x3EFF one cycle later; no spontaneous wrap while idle; next accept -> wr_ptr=0, `wrap` pulse, `addr_out`=0x100.
- Mid-stream `clear` together with `incr` -> next cycle all pointers 0, `empty`=1, sticky flags clear; async reset_n pulse between clock edges -> outputs reset immediately.
